// File: rtl/dram_block_copier.sv
// Block copy / fill engine driving one DRAM port: memmove-safe copy (RD/WR per word)
// or constant fill (one word per cycle), with range check, abort and status.
module dram_block_copier #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_TOP = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] words_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned SUM_W = ADDR_W + 1;
    localparam logic [SUM_W-1:0] TOP = SUM_W'(MEM_TOP);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d, idx_q, idx_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              desc_q, desc_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] wd_q, wd_d;
    logic              busy_q, busy_d, done_q, done_d, we_q, we_d, rdsel_q, rdsel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [SUM_W-1:0]  src_end, dst_end, src_lim;
    logic              range_err, overlap, last;
    logic [ADDR_W-1:0] idx_step;

    // Operand checks on the raw start inputs, widened by one bit so sums cannot wrap
    always_comb begin
        src_lim   = {1'b0, src_addr} + {1'b0, len};
        src_end   = src_lim - SUM_W'(1);
        dst_end   = {1'b0, dst_addr} + {1'b0, len} - SUM_W'(1);
        range_err = (len != '0) && ((!mode && (src_end > TOP)) || (dst_end > TOP));
        overlap   = !mode && (dst_addr > src_addr) && ({1'b0, dst_addr} < src_lim);
        last      = desc_q ? (idx_q == '0) : (idx_q == len_q - ADDR_W'(1));
        idx_step  = desc_q ? idx_q - ADDR_W'(1) : idx_q + ADDR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        desc_d  = desc_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = len;
                    fill_d = fill_data;
                    desc_d = overlap;
                    idx_d  = overlap ? len - ADDR_W'(1) : '0;
                    err_d  = 1'b0;
                    wd_d   = '0;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (range_err) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = mode ? S_FILL : S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = abort ? S_DONE : S_WR;
                if (abort) err_d = 1'b1;
            end
            S_WR, S_FILL: begin
                wd_d = wd_q + ADDR_W'(1);
                if (abort) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_step;
                    state_d = (state_q == S_WR) ? S_RD : S_FILL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered as a decode of the next state
        busy_d  = (state_d == S_RD) || (state_d == S_WR) || (state_d == S_FILL);
        done_d  = (state_d == S_DONE);
        we_d    = (state_d == S_WR) || (state_d == S_FILL);
        rdsel_d = (state_d == S_WR);
        wdata_d = (state_d == S_FILL) ? fill_d : '0;
        addr_d  = '0;
        if (state_d == S_RD)   addr_d = src_d + idx_d;
        if (we_d)              addr_d = dst_d + idx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
            desc_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            rdsel_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            desc_q  <= desc_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            rdsel_q <= rdsel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Read data arrives during WR, so the copy path forwards it straight to the port
    assign mem_wdata  = rdsel_q ? mem_rdata : wdata_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = wd_q;

endmodule

// File: tb/tb_dram_block_copier.sv
// Directed bench for dram_block_copier: DRAM model, reference memory and a
// scoreboard of expected reads/writes checked as the DUT issues them.
module tb_dram_block_copier;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned TOP = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, mode, abort;
    logic [AW-1:0] src_addr, dst_addr, len;
    logic [DW-1:0] fill_data;
    logic          busy, done, err, mem_we;
    logic [AW-1:0] words_done, mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] dram    [0:TOP];
    logic [DW-1:0] ref_mem [0:TOP];
    logic [DW-1:0] rdata_q;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    logic [31:0] wr_q [$];
    logic [15:0] rd_q [$];

    int tests = 0;
    int fails = 0;
    int cyc, busy_n, done_at, wr_n;

    dram_block_copier #(.ADDR_W(AW), .DATA_W(DW), .MEM_TOP(TOP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
        .err(err), .words_done(words_done), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous DRAM port: write on we, otherwise registered read
    always @(posedge clk) begin
        if (pre_we) dram[pre_addr] <= pre_data;
        else if (mem_we && (mem_addr <= AW'(TOP))) dram[mem_addr] <= mem_wdata;
        else if (mem_addr <= AW'(TOP)) rdata_q <= dram[mem_addr];
    end
    assign mem_rdata = rdata_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input logic [DW-1:0] v);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = v;
        @(posedge clk);
        #1;
        pre_we     = 1'b0;
        ref_mem[a] = v;
    endtask

    // Advance one cycle, sample after the edge and score any DRAM access
    task automatic tick();
        logic [31:0] e;
        logic [15:0] r;
        @(posedge clk);
        #1;
        cyc++;
        if (busy) busy_n++;
        if (done && done_at == 0) done_at = cyc;
        if (mem_we) begin
            wr_n++;
            if (wr_q.size() == 0) chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            else begin
                e = wr_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[31:16]));
                chk("wr_data", 32'(mem_wdata), 32'(e[15:0]));
            end
        end else if (busy) begin
            if (rd_q.size() == 0) chk("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
            else begin
                r = rd_q.pop_front();
                chk("rd_addr", 32'(mem_addr), 32'(r));
            end
        end
    endtask

    // Reference behaviour: first nrd reads and nwr writes of the transfer
    task automatic model_xfer(input logic m, input int s, input int d, input int l,
                              input logic [DW-1:0] f, input int nwr, input int nrd);
        bit desc;
        int i;
        logic [DW-1:0] v;
        if (l == 0) return;
        if ((!m && (s + l - 1 > int'(TOP))) || (d + l - 1 > int'(TOP))) return;
        desc = !m && (d > s) && (d < s + l);
        for (int k = 0; k < l; k++) begin
            i = desc ? l - 1 - k : k;
            if (!m && k < nrd) rd_q.push_back(16'(s + i));
            if (k < nwr) begin
                v = m ? f : ref_mem[s + i];
                wr_q.push_back({16'(d + i), 16'(v)});
                ref_mem[d + i] = v;
            end
        end
    endtask

    task automatic run(input logic m, input int s, input int d, input int l,
                       input logic [DW-1:0] f, input int abort_at, input int nwr, input int nrd);
        model_xfer(m, s, d, l, f, nwr, nrd);
        mode      = m;
        src_addr  = AW'(s);
        dst_addr  = AW'(d);
        len       = AW'(l);
        fill_data = f;
        start     = 1'b1;
        cyc = 0; busy_n = 0; done_at = 0; wr_n = 0;
        tick();
        start = 1'b0;
        while (done_at == 0 && cyc < 200) begin
            if (abort_at != 0 && busy_n == abort_at) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        chk("done_seen", 32'(done_at != 0), 32'd1);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        wr_q.delete();
        rd_q.delete();
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int k = 0; k <= int'(TOP); k++) ref_mem[k] = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        poke(0, 16'd13); poke(1, 16'd15); poke(2, 16'd22);
        poke(10, 16'd1); poke(11, 16'd2); poke(12, 16'd3); poke(13, 16'd4);
        for (int k = 30; k <= 38; k++) poke(k, 16'hAAAA);
        rst_n = 1'b1;
        tick();

        // Basic ascending copy
        run(1'b0, 0, 100, 3, '0, 0, 3, 3);
        chk("copy_busy_cycles", 32'(busy_n), 32'd6);
        chk("copy_done_cycle", 32'(done_at), 32'd7);
        chk("copy_words_done", 32'(words_done), 32'd3);
        chk("copy_err", 32'(err), 32'd0);
        chk("copy_writes", 32'(wr_n), 32'd3);
        chk("copy_mem100", 32'(dram[100]), 32'd13);
        chk("copy_mem102", 32'(dram[102]), 32'd22);

        // Overlapping copy must go descending
        run(1'b0, 10, 12, 4, '0, 0, 4, 4);
        for (int k = 0; k < 4; k++) chk("desc_final", 32'(dram[12 + k]), 32'(k + 1));
        chk("desc_words_done", 32'(words_done), 32'd4);

        // Fill
        run(1'b1, 0, 30, 9, 16'h0000, 0, 9, 0);
        chk("fill_busy_cycles", 32'(busy_n), 32'd9);
        chk("fill_done_cycle", 32'(done_at), 32'd10);
        chk("fill_words_done", 32'(words_done), 32'd9);
        for (int k = 30; k <= 38; k++) chk("fill_mem", 32'(dram[k]), 32'd0);

        // Out-of-range source, then zero length
        run(1'b0, 1020, 0, 8, '0, 0, 0, 0);
        chk("range_no_write", 32'(wr_n), 32'd0);
        chk("range_done_cycle", 32'(done_at), 32'd1);
        chk("range_err", 32'(err), 32'd1);
        chk("range_busy", 32'(busy_n), 32'd0);
        run(1'b0, 5, 6, 0, '0, 0, 0, 0);
        chk("len0_no_write", 32'(wr_n), 32'd0);
        chk("len0_done_cycle", 32'(done_at), 32'd1);
        chk("len0_err", 32'(err), 32'd0);

        // Fill at top edge is legal; one past is not
        run(1'b1, 0, 1020, 5, 16'h5A5A, 0, 5, 0);
        chk("top_fill_err", 32'(err), 32'd0);
        chk("top_fill_mem", 32'(dram[1024]), 32'h5A5A);
        run(1'b1, 0, 1020, 6, 16'h1111, 0, 0, 0);
        chk("over_fill_err", 32'(err), 32'd1);
        chk("over_fill_writes", 32'(wr_n), 32'd0);

        // Abort in the 4th fill cycle
        run(1'b1, 0, 200, 10, 16'h7777, 4, 4, 0);
        chk("abort_words_done", 32'(words_done), 32'd4);
        chk("abort_err", 32'(err), 32'd1);
        chk("abort_writes", 32'(wr_n), 32'd4);

        // Abort during the first RD: no write
        run(1'b0, 0, 300, 3, '0, 1, 0, 1);
        chk("abort_rd_words", 32'(words_done), 32'd0);
        chk("abort_rd_err", 32'(err), 32'd1);
        chk("abort_rd_writes", 32'(wr_n), 32'd0);

        // Start with abort in IDLE is ignored
        run(1'b1, 0, 400, 2, 16'h0101, 0, 2, 0);
        chk("pre_err", 32'(err), 32'd0);
        start = 1'b1; abort = 1'b1; mode = 1'b1; len = AW'(3); dst_addr = AW'(500);
        cyc = 0; busy_n = 0; done_at = 0; wr_n = 0;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        chk("sa_busy", 32'(busy_n), 32'd0);
        chk("sa_done", 32'(done_at), 32'd0);
        chk("sa_words_done", 32'(words_done), 32'd2);
        chk("sa_writes", 32'(wr_n), 32'd0);

        // Reset during WR of a copy
        model_xfer(1'b0, 0, 600, 3, '0, 1, 1);
        mode = 1'b0; src_addr = AW'(0); dst_addr = AW'(600); len = AW'(3);
        start = 1'b1;
        cyc = 0; busy_n = 0; done_at = 0; wr_n = 0;
        tick();
        start = 1'b0;
        while (!mem_we && cyc < 10) tick();
        chk("rst_reached_wr", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        wr_q.delete(); rd_q.delete();
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("rst_no_done", 32'(done_at), 32'd0);
        chk("rst_no_write", 32'(wr_n), 32'd1);
        chk("rst_no_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dram_block_copier.md
DRAM_BLOCK_COPIER -- requirements
Module: dram_block_copier

Interface
REQ-001 Parameter ADDR_W, default 16, address width, matching the DRAM port address.
REQ-002 Parameter DATA_W, default 16, data width, matching the DRAM port data.
REQ-003 Parameter MEM_TOP, default 1024, highest legal DRAM word address.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: request a transfer; sampled only in IDLE.
REQ-007 Port mode, input, 1: 0 = copy, 1 = fill; sampled with start.
REQ-008 Port src_addr, input, ADDR_W: copy source base; sampled with start.
REQ-009 Port dst_addr, input, ADDR_W: destination base; sampled with start.
REQ-010 Port len, input, ADDR_W: word count; sampled with start.
REQ-011 Port fill_data, input, DATA_W: fill value; sampled with start.
REQ-012 Port abort, input, 1: terminate an active transfer.
REQ-013 Port busy, output, 1: a transfer is active.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port err, output, 1: status of the last transfer; holds until the next start.
REQ-016 Port words_done, output, ADDR_W: count of words written in the current or last transfer.
REQ-017 Port mem_we, output, 1: drives one DRAM port write_en slice.
REQ-018 Port mem_addr, output, ADDR_W: drives that port's addr slice.
REQ-019 Port mem_wdata, output, DATA_W: drives that port's data_in slice.
REQ-020 Port mem_rdata, input, DATA_W: from that port's data_out slice; valid the cycle after a read (mem_we=0) cycle.

Function
REQ-021 States: IDLE, RD, WR, FILL, DONE.
REQ-022 IDLE plus start=1 plus abort=0: operands are latched, err and words_done are cleared, and the next state is selected per REQ-023 to REQ-026.
REQ-023 Range check uses ADDR_W+1-bit sums. If len>0 and either (src+len-1)>MEM_TOP (copy only) or (dst+len-1)>MEM_TOP: go to DONE with err=1 and make no DRAM access.
REQ-024 If len=0: go to DONE with err=0 and make no DRAM access.
REQ-025 Copy with dst>src and dst<src+len: descending order, index len-1 down to 0. All other copies are ascending, index 0 up to len-1.
REQ-026 Next state after a valid start: copy goes to RD, fill goes to FILL.
REQ-027 RD drives mem_we=0 and mem_addr=src+idx, then goes to WR.
REQ-028 WR drives mem_we=1, mem_addr=dst+idx and mem_wdata=mem_rdata. It increments words_done and goes to RD for the next index, or to DONE after the last index.
REQ-029 FILL drives mem_we=1, mem_addr=dst+idx and mem_wdata=fill_data, one word per cycle, ascending. It increments words_done and goes to DONE after the last index.
REQ-030 DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-031 busy=1 in RD, WR and FILL only; busy=0 in IDLE and DONE.
REQ-032 In IDLE and DONE: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 Timing with start accepted at edge E0: copy of N words gives busy for 2N cycles, with done in the cycle after the final WR.
REQ-034 Timing with start accepted at edge E0: fill of N words gives busy for N cycles, with done in the cycle after the final FILL.
REQ-035 abort=1 in RD, WR or FILL: the access in the current cycle completes, the next state is DONE, err=1, and words_done keeps the words written including the current cycle.
REQ-036 start while busy or in DONE is ignored.
REQ-037 start and abort both high in IDLE: abort wins, the start is ignored and outputs are unchanged.
REQ-038 The index counter never wraps; the range check in REQ-023 guarantees all addresses stay at or below MEM_TOP.
REQ-039 All mem_* outputs are decoded from registered state only; there is no combinational path from start or abort to mem_*.

Reset
REQ-040 rst_n=0 forces IDLE immediately, asynchronously, mid-transfer included.
REQ-041 Reset values: busy=0, done=0, err=0, words_done=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-042 A transfer interrupted by reset is abandoned, with no done pulse.

Verification
REQ-043 DRAM words 0-2 = 13, 15, 22; copy src=0, dst=100, len=3 -> access sequence RD0, WR100(13), RD1, WR101(15), RD2, WR102(22); busy 6 cycles; done in cycle 7; words_done=3; err=0.
REQ-044 DRAM words 10-13 = 1, 2, 3, 4; copy src=10, dst=12, len=4 -> descending order; final words 12-15 = 1, 2, 3, 4.
REQ-045 Fill dst=30, len=9, fill_data=0 -> words 30-38 = 0; busy 9 cycles; words_done=9.
REQ-046 Copy src=1020, dst=0, len=8 -> no mem_we asserted; done with err=1 in the cycle after start. Then len=0 -> done with err=0 and no access.
REQ-047 Fill len=10 with abort asserted in the 4th FILL cycle -> words_done=4, err=1, exactly 4 writes.
REQ-048 rst_n low during WR of a copy -> mem_we=0 and busy=0 without waiting for a clock edge, and no done pulse.
